// File: rtl/pipe_stage_skid_if.sv
// rtl/pipe_stage_skid_if.sv - upstream/downstream handshake bundle for pipe_stage_skid
// Ports (signals):
//   in_valid/in_ready/in_data/in_ctrl     upstream side of the stage
//   out_valid/out_ready/out_data/out_ctrl downstream side of the stage
// Modports:
//   slave  - the stage itself (consumes in_*, produces out_*)
//   master - the environment around the stage (produces in_*, consumes out_*)
interface pipe_stage_skid_if #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 3
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;

  modport slave (
    input  in_valid, in_data, in_ctrl, out_ready,
    output in_ready, out_valid, out_data, out_ctrl
  );

  modport master (
    output in_valid, in_data, in_ctrl, out_ready,
    input  in_ready, out_valid, out_data, out_ctrl
  );
endinterface

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - valid/ready pipeline stage register with flush and optional skid entry
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   bus        handshake bundle (slave view): in_* from upstream, out_* to downstream
//   flush      synchronous kill of every held entry
//   occupancy  number of held entries (0..2, at most 1 when SKID=0)
module pipe_stage_skid #(
  parameter int                DATA_W   = 32,
  parameter int                CTRL_W   = 3,
  parameter logic [CTRL_W-1:0] CTRL_RST = 3'b010,
  parameter int                SKID     = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pipe_stage_skid_if.slave     bus,
  input  logic                 flush,
  output logic [1:0]           occupancy
);

  // State value equals the number of held entries.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;

  logic in_ready_c;
  logic out_valid_c;
  logic acc;
  logic deq;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      main_data_q <= '0;
      main_ctrl_q <= CTRL_RST;
      skid_data_q <= '0;
      skid_ctrl_q <= CTRL_RST;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
    end
  end

  // Next-state logic. The main entry is forced to the bubble value whenever
  // it empties, so the outputs can drive straight from the flops.
  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    acc         = bus.in_valid & in_ready_c;
    deq         = out_valid_c & bus.out_ready;

    if (flush) begin
      // An item accepted this cycle is dropped; upstream still sees it taken.
      state_d     = ST_EMPTY;
      main_data_d = '0;
      main_ctrl_d = CTRL_RST;
      skid_data_d = '0;
      skid_ctrl_d = CTRL_RST;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (acc) begin
            state_d     = ST_ONE;
            main_data_d = bus.in_data;
            main_ctrl_d = bus.in_ctrl;
          end
        end
        ST_ONE: begin
          if (acc && deq) begin
            main_data_d = bus.in_data;
            main_ctrl_d = bus.in_ctrl;
          end else if (acc) begin
            // Only reachable with a skid entry: without one, in_ready
            // follows out_ready, so a full stage cannot accept without deq.
            if (SKID != 0) begin
              state_d     = ST_TWO;
              skid_data_d = bus.in_data;
              skid_ctrl_d = bus.in_ctrl;
            end else begin
              main_data_d = bus.in_data;
              main_ctrl_d = bus.in_ctrl;
            end
          end else if (deq) begin
            state_d     = ST_EMPTY;
            main_data_d = '0;
            main_ctrl_d = CTRL_RST;
          end
        end
        ST_TWO: begin
          if (deq) begin
            state_d     = ST_ONE;
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
            skid_data_d = '0;
            skid_ctrl_d = CTRL_RST;
          end
        end
        default: begin
          state_d     = ST_EMPTY;
          main_data_d = '0;
          main_ctrl_d = CTRL_RST;
          skid_data_d = '0;
          skid_ctrl_d = CTRL_RST;
        end
      endcase
    end
  end

  // Output decode. With a skid entry, in_ready comes from the state flops
  // only, breaking the combinational out_ready -> in_ready chain.
  always_comb begin
    out_valid_c = (state_q != ST_EMPTY);
    if (SKID != 0) begin
      in_ready_c = (state_q != ST_TWO);
    end else begin
      in_ready_c = ~out_valid_c | bus.out_ready;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_data  = main_data_q;
  assign bus.out_ctrl  = main_ctrl_q;
  assign occupancy     = state_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - bench for pipe_stage_skid in both SKID modes
module tb_pipe_stage_skid;
  localparam int         DW   = 32;
  localparam int         CW   = 3;
  localparam logic [2:0] CRST = 3'b010;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic          flush = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [CW-1:0] in_ctrl = '0;
  logic [1:0]    occ1, occ0;

  pipe_stage_skid_if #(.DATA_W(DW), .CTRL_W(CW)) b1 ();
  pipe_stage_skid_if #(.DATA_W(DW), .CTRL_W(CW)) b0 ();

  assign b1.in_valid  = in_valid;
  assign b1.in_data   = in_data;
  assign b1.in_ctrl   = in_ctrl;
  assign b1.out_ready = out_ready;
  assign b0.in_valid  = in_valid;
  assign b0.in_data   = in_data;
  assign b0.in_ctrl   = in_ctrl;
  assign b0.out_ready = out_ready;

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CTRL_RST(CRST), .SKID(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(b1), .flush(flush), .occupancy(occ1)
  );
  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CTRL_RST(CRST), .SKID(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(b0), .flush(flush), .occupancy(occ0)
  );

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: each stage is a FIFO of capacity 2 (SKID=1) or 1 (SKID=0).
  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } item_t;

  item_t q1[$];
  item_t q0[$];
  bit a1, d1, a0, d0;

  function automatic bit rdy1_exp();
    return q1.size() < 2;
  endfunction

  function automatic bit rdy0_exp();
    return (q0.size() == 0) || out_ready;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q1.delete();
      q0.delete();
    end else begin
      a1 = in_valid && rdy1_exp();
      d1 = (q1.size() > 0) && out_ready;
      a0 = in_valid && rdy0_exp();
      d0 = (q0.size() > 0) && out_ready;
      if (flush) begin
        q1.delete();
        q0.delete();
      end else begin
        if (d1) void'(q1.pop_front());
        if (a1) q1.push_back({in_data, in_ctrl});
        if (d0) void'(q0.pop_front());
        if (a0) q0.push_back({in_data, in_ctrl});
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("s1 out_valid", {31'd0, b1.out_valid}, {31'd0, q1.size() > 0});
      chk("s1 in_ready",  {31'd0, b1.in_ready},  {31'd0, rdy1_exp()});
      chk("s1 out_data",  b1.out_data, (q1.size() > 0) ? q1[0].d : 32'd0);
      chk("s1 out_ctrl",  {29'd0, b1.out_ctrl}, {29'd0, (q1.size() > 0) ? q1[0].c : CRST});
      chk("s1 occupancy", {30'd0, occ1}, q1.size());
      chk("s0 out_valid", {31'd0, b0.out_valid}, {31'd0, q0.size() > 0});
      chk("s0 in_ready",  {31'd0, b0.in_ready},  {31'd0, rdy0_exp()});
      chk("s0 out_data",  b0.out_data, (q0.size() > 0) ? q0[0].d : 32'd0);
      chk("s0 out_ctrl",  {29'd0, b0.out_ctrl}, {29'd0, (q0.size() > 0) ? q0[0].c : CRST});
      chk("s0 occupancy", {30'd0, occ0}, q0.size());
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    in_valid = 1'b0;
    cyc();
    flush = 1'b0;
  endtask

  initial begin
    // Reset held while upstream (illegally) drives a payload.
    in_valid = 1'b1;
    in_data = 32'hDEADBEEF;
    in_ctrl = 3'b101;
    out_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    chk("rst imm out_valid", {31'd0, b1.out_valid}, 32'd0);
    repeat (3) begin
      cyc();
      chk("rst out_valid", {31'd0, b1.out_valid}, 32'd0);
      chk("rst out_data", b1.out_data, 32'd0);
      chk("rst out_ctrl", {29'd0, b1.out_ctrl}, 32'd2);
      chk("rst occupancy", {30'd0, occ1}, 32'd0);
      chk("rst in_ready s1", {31'd0, b1.in_ready}, 32'd1);
      chk("rst in_ready s0", {31'd0, b0.in_ready}, 32'd1);
    end
    rst_n = 1'b1;
    cyc();
    chk("post rst data", b1.out_data, 32'hDEADBEEF);
    chk("post rst valid", {31'd0, b1.out_valid}, 32'd1);
    chk("post rst data s0", b0.out_data, 32'hDEADBEEF);

    // Streaming 1..8 with out_ready held high.
    do_flush();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data = i;
      in_ctrl = 3'(i);
      cyc();
      chk("stream data", b1.out_data, i);
      chk("stream occ", {30'd0, occ1}, 32'd1);
      chk("stream in_ready", {31'd0, b1.in_ready}, 32'd1);
    end

    // Backpressure: 1 shown, out_ready low for 3 cycles, 2 lands in skid.
    do_flush();
    out_ready = 1'b1; in_valid = 1'b1; in_data = 1;
    cyc();
    chk("bp first", b1.out_data, 32'd1);
    out_ready = 1'b0; in_data = 2;
    cyc();
    chk("bp occ2", {30'd0, occ1}, 32'd2);
    chk("bp in_ready", {31'd0, b1.in_ready}, 32'd0);
    in_data = 3;
    cyc();
    cyc();
    chk("bp hold data", b1.out_data, 32'd1);
    chk("bp hold occ", {30'd0, occ1}, 32'd2);
    out_ready = 1'b1;
    cyc();
    chk("bp out 2", b1.out_data, 32'd2);
    chk("bp occ1", {30'd0, occ1}, 32'd1);
    cyc();
    chk("bp out 3", b1.out_data, 32'd3);
    in_data = 4;
    cyc();
    chk("bp out 4", b1.out_data, 32'd4);
    in_valid = 1'b0;
    cyc();
    chk("bp empty", {31'd0, b1.out_valid}, 32'd0);

    // Flush while holding 5,6 with 7 offered.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 5;
    cyc();
    in_data = 6;
    cyc();
    chk("fl occ2", {30'd0, occ1}, 32'd2);
    flush = 1'b1; in_data = 7;
    cyc();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("fl occ", {30'd0, occ1}, 32'd0);
    chk("fl valid", {31'd0, b1.out_valid}, 32'd0);
    chk("fl data", b1.out_data, 32'd0);
    chk("fl ctrl", {29'd0, b1.out_ctrl}, 32'd2);
    repeat (3) begin
      cyc();
      chk("fl no 7", {31'd0, b1.out_valid}, 32'd0);
    end

    // SKID=0 combinational in_ready.
    out_ready = 1'b1; in_valid = 1'b1; in_data = 32'hA;
    cyc();
    chk("s0 first", b0.out_data, 32'hA);
    out_ready = 1'b0; in_data = 32'hB;
    #1;
    chk("s0 rdy low", {31'd0, b0.in_ready}, 32'd0);
    cyc();
    chk("s0 hold", b0.out_data, 32'hA);
    out_ready = 1'b1;
    #1;
    chk("s0 rdy high", {31'd0, b0.in_ready}, 32'd1);
    cyc();
    chk("s0 replace", b0.out_data, 32'hB);

    // Drain of a single item.
    do_flush();
    out_ready = 1'b1; in_valid = 1'b1; in_data = 9;
    cyc();
    chk("drain 9", b1.out_data, 32'd9);
    in_valid = 1'b0;
    cyc();
    chk("drain data", b1.out_data, 32'd0);
    chk("drain ctrl", {29'd0, b1.out_ctrl}, 32'd2);
    chk("drain valid", {31'd0, b1.out_valid}, 32'd0);

    // Random traffic with occasional flush and one mid-run reset.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid rst valid", {31'd0, b1.out_valid}, 32'd0);
        chk("mid rst occ", {30'd0, occ1}, 32'd0);
        chk("mid rst data s0", b0.out_data, 32'd0);
        cyc();
        rst_n = 1'b1;
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = (i % 400 < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      flush     = ($urandom_range(0, 31) == 0);
      in_data   = $urandom;
      in_ctrl   = 3'($urandom_range(0, 7));
      cyc();
    end
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline-stage register with a valid/ready handshake, synchronous flush and an optional 2-entry skid buffer. It generalises the fixed inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) of the rv32i core into one reusable block. Payload width, control width and control bubble value are set per stage. Backpressure lets the core stall on multi-cycle memory or divide without tying every pipeline register to a global stall net. Every stage boundary instantiates one copy.

## Interface
Parameters:
- DATA_W, 32: width of data payload (pc, alu result, load data, inst, rd packed by instantiator); bubble value all zeros.
- CTRL_W, 3: width of control payload (reg write enable, write-data select, branch taken, ...).
- CTRL_RST, 3'b010: control bubble value; encodes inactive state of each control bit (e.g. active-low reg write = 1).
- SKID, 1: 1 = 2-entry skid buffer, in_ready driven only from flops; 0 = single register, in_ready combinational from out_ready.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  upstream stage holds valid payload.
- in_ready  out  1  stage accepts payload this cycle.
- in_data  in  DATA_W  data payload.
- in_ctrl  in  CTRL_W  control payload.
- out_valid  out  1  payload presented downstream.
- out_ready  in  1  downstream consumes payload this cycle.
- out_data  out  DATA_W  data payload; zeros when out_valid=0.
- out_ctrl  out  CTRL_W  control payload; CTRL_RST when out_valid=0.
- flush  in  1  synchronous kill of all held entries (branch/jump redirect).
- occupancy  out  2  number of held entries (0..2; max 1 when SKID=0).

## Operation
- Accept: acc = in_valid & in_ready. Dequeue: deq = out_valid & out_ready.
- Storage: main entry (drives outputs) and, when SKID=1, a skid entry. Each entry holds valid, data and ctrl.
- SKID=1 state machine (EMPTY/ONE/TWO = occupancy 0/1/2):
  - EMPTY: acc -> ONE, main <= input.
  - ONE: acc & ~deq -> TWO, skid <= input. acc & deq -> ONE, main <= input. ~acc & deq -> EMPTY, main <= bubble. Otherwise hold.
  - TWO: in_ready=0. deq -> ONE, main <= skid, skid <= bubble. Otherwise hold.
- SKID=1: in_ready = (state != TWO), a pure flop decode.
- SKID=0: in_ready = ~out_valid | out_ready.
  - acc -> main <= input.
  - ~acc & deq -> main <= bubble.
  - Otherwise hold.
- Bubble = {valid=0, data=0, ctrl=CTRL_RST}.
  - Outputs never show stale payload while out_valid=0.
  - Downstream write enables are therefore inactive with no gating.
- Flush has priority over acc and deq. Next state is EMPTY with all entries set to bubble, and any input accepted in the flush cycle is discarded.
  - The upstream handshake in that cycle still completes, so upstream treats the item as consumed.
- Order strictly FIFO. No payload is dropped or duplicated except by flush.
- Payload is not modified; the block is width-transparent.

## Timing
- Reset (rst_n=0, immediate, no clock needed):
  - out_valid=0, out_data=0, out_ctrl=CTRL_RST, occupancy=0.
  - in_ready=1 (SKID=1) or 1 via ~out_valid (SKID=0).
  - Upstream must not assert in_valid during reset.
- Reset deassertion is synchronous to clk at the instantiating level; first accept possible on first edge after release.
- Latency: accepted payload appears on out_* on the edge of acceptance (1 cycle) when the stage was empty.
- Throughput: 1 item/cycle sustained with out_ready=1, both SKID modes.
- SKID=1 stall: out_ready drop is absorbed by skid; in_ready falls one cycle later, after the cycle the skid fills. No combinational in_ready<-out_ready path.
- Reset asserted mid-transfer clears both entries immediately. Held payload is lost by design.
- Simultaneous flush + acc + deq in any state: result EMPTY on next edge.

## Test plan
- Reset: hold rst_n=0 with in_valid=1, in_data=32'hDEADBEEF, CTRL_RST=3'b010 -> out_valid=0, out_data=0, out_ctrl=3'b010, occupancy=0 throughout; release -> first edge with in_valid=1 gives out_data=32'hDEADBEEF, out_valid=1.
- Streaming: SKID=1, out_ready=1, in_data=1..8 on consecutive cycles -> out_data=1..8 on consecutive cycles, in_ready stays 1, occupancy stays 1.
- Backpressure: SKID=1, stream 1,2,3,4; drop out_ready while out_data=1 for 3 cycles -> 2 captured in skid, occupancy=2, in_ready=0, 3 held upstream; restore out_ready -> outputs 1,2,3,4 in order, none lost or duplicated.
- Flush: occupancy=2 holding 5,6, assert flush with in_valid=1, in_data=7 -> next cycle occupancy=0, out_valid=0, out_data=0, out_ctrl=CTRL_RST; 7 never appears.
- SKID=0: out_ready=0 with out_valid=1 -> in_ready=0 same cycle; out_ready=1 with in_valid=1 -> in_ready=1 same cycle and replacement item appears next edge.
- Drain: single item 9, then in_valid=0 and out_ready=1 -> one cycle out_data=9, next cycle out_data=0, out_ctrl=CTRL_RST, out_valid=0.
